// File: rtl/codec_pkg.sv
// Shared constants and helpers for the I2S codec interface: counter geometry,
// clock tap positions and the data-slot window inside each channel half.
package codec_pkg;

    localparam int CNT_W      = 11;
    localparam int DATA_W_DEF = 16;

    localparam int MCLK_BIT  = 1;
    localparam int SCLK_BIT  = 4;
    localparam int LRCLK_BIT = 10;

    localparam int SLOT_LSB = 5;
    localparam int SLOT_W   = 5;
    localparam int IDX_W    = 4;

    localparam logic [SLOT_W-1:0] FIRST_SLOT = 5'd1;
    localparam logic [SLOT_W-1:0] LAST_SLOT  = 5'd16;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    function automatic logic is_data_slot(input logic [SLOT_W-1:0] k);
        return (k >= FIRST_SLOT) && (k <= LAST_SLOT);
    endfunction

endpackage

// File: rtl/codec_clk_gen.sv
// Free-running frame counter and the edge strobes decoded from it. Each strobe
// is high in the clk whose rising edge performs the named counter transition.
module codec_clk_gen
    import codec_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             sclk_rise,
    output logic             sclk_fall,
    output logic             lr_rise,
    output logic             frame_wrap
);

    logic [CNT_W-1:0] cnt_r;

    // Frame counter, wraps 2047 -> 0 naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign cnt        = cnt_r;
    assign sclk_rise  = (cnt_r[SCLK_BIT:0] == 5'b01111);
    assign sclk_fall  = (cnt_r[SCLK_BIT:0] == 5'b11111);
    assign lr_rise    = (cnt_r[LRCLK_BIT-1:0] == 10'h3FF) && (cnt_r[LRCLK_BIT] == 1'b0);
    assign frame_wrap = (&cnt_r);

endmodule

// File: rtl/codec_intf.sv
// I2S master for the audio codec: generates MCLK/SCLK/LRCLK, deserialises the
// ADC stream into lft_in/rht_in and serialises held DAC words onto SDin.
module codec_intf
    import codec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              MCLK,
    output logic              SCLK,
    output logic              LRCLK,
    output logic              RSTn,
    input  logic              SDout,
    output logic              SDin,
    output logic [DATA_W-1:0] lft_in,
    output logic [DATA_W-1:0] rht_in,
    output logic              valid,
    input  logic [DATA_W-1:0] lft_out,
    input  logic [DATA_W-1:0] rht_out
);

    logic [CNT_W-1:0]  cnt_s;
    logic              sclk_rise_s;
    logic              sclk_fall_s;
    logic              lr_rise_s;
    logic              frame_wrap_s;

    logic [CNT_W-1:0]  nxt_cnt_s;
    logic [SLOT_W-1:0] rx_slot_s;
    logic [SLOT_W-1:0] tx_slot_s;
    logic [IDX_W-1:0]  tx_idx_s;
    logic [DATA_W-1:0] tx_word_s;
    logic              tx_bit_s;

    logic [DATA_W-1:0] rx_shift_r;
    logic [DATA_W-1:0] lft_in_r;
    logic [DATA_W-1:0] rht_in_r;
    logic [DATA_W-1:0] hold_l_r;
    logic [DATA_W-1:0] hold_r_r;
    logic              valid_r;
    logic              sdin_r;
    logic              rstn_r;

    codec_clk_gen u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .cnt        (cnt_s),
        .sclk_rise  (sclk_rise_s),
        .sclk_fall  (sclk_fall_s),
        .lr_rise    (lr_rise_s),
        .frame_wrap (frame_wrap_s)
    );

    // SDin changes on the falling SCLK edge, so it must describe the slot being entered.
    assign nxt_cnt_s = cnt_s + CNT_W'(1);
    assign rx_slot_s = cnt_s[SLOT_LSB +: SLOT_W];
    assign tx_slot_s = nxt_cnt_s[SLOT_LSB +: SLOT_W];
    assign tx_idx_s  = IDX_W'(LAST_SLOT - tx_slot_s);

    // Select the outgoing bit for the slot about to start.
    always_comb begin
        tx_word_s = hold_l_r;
        tx_bit_s  = 1'b0;
        if (chan_e'(nxt_cnt_s[LRCLK_BIT]) == CH_RIGHT) begin
            tx_word_s = hold_r_r;
        end else begin
            tx_word_s = hold_l_r;
        end
        if (is_data_slot(tx_slot_s)) begin
            tx_bit_s = tx_word_s[tx_idx_s];
        end else begin
            tx_bit_s = 1'b0;
        end
    end

    // Receive shifter, sample latches, transmit holding registers and codec reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift_r <= {DATA_W{1'b0}};
            lft_in_r   <= {DATA_W{1'b0}};
            rht_in_r   <= {DATA_W{1'b0}};
            hold_l_r   <= {DATA_W{1'b0}};
            hold_r_r   <= {DATA_W{1'b0}};
            valid_r    <= 1'b0;
            sdin_r     <= 1'b0;
            rstn_r     <= 1'b0;
        end else begin
            rstn_r  <= 1'b1;
            valid_r <= frame_wrap_s;
            if (sclk_rise_s && is_data_slot(rx_slot_s)) begin
                rx_shift_r <= {rx_shift_r[DATA_W-2:0], SDout};
            end
            if (lr_rise_s) begin
                lft_in_r <= rx_shift_r;
            end
            if (frame_wrap_s) begin
                rht_in_r <= rx_shift_r;
            end
            // Words are taken only at the valid clk so the frame in flight is immune to input changes.
            if (valid_r) begin
                hold_l_r <= lft_out;
                hold_r_r <= rht_out;
            end
            if (sclk_fall_s) begin
                sdin_r <= tx_bit_s;
            end
        end
    end

    assign MCLK   = cnt_s[MCLK_BIT];
    assign SCLK   = cnt_s[SCLK_BIT];
    assign LRCLK  = cnt_s[LRCLK_BIT];
    assign RSTn   = rstn_r;
    assign SDin   = sdin_r;
    assign lft_in = lft_in_r;
    assign rht_in = rht_in_r;
    assign valid  = valid_r;

endmodule

// File: tb/tb_codec_intf.sv
// Self-checking bench for codec_intf: a behavioural I2S codec drives SDout and
// decodes SDin from its own frame counter; per-frame vectors plus corner sequences.
module tb_codec_intf;

    logic        clk = 1'b0;
    logic        rst;
    logic        SDout;
    logic [15:0] lft_out, rht_out;
    logic        MCLK, SCLK, LRCLK, RSTn, SDin, valid;
    logic [15:0] lft_in, rht_in;

    codec_intf #(.DATA_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .MCLK    (MCLK),
        .SCLK    (SCLK),
        .LRCLK   (LRCLK),
        .RSTn    (RSTn),
        .SDout   (SDout),
        .SDin    (SDin),
        .lft_in  (lft_in),
        .rht_in  (rht_in),
        .valid   (valid),
        .lft_out (lft_out),
        .rht_out (rht_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] tx_l, tx_r, cod_l, cod_r, exp_l, exp_r, exp_al, exp_ar;
    } vec_t;
    vec_t vecs [4];

    int          total = 0;
    int          bad   = 0;
    int          clk_err = 0;
    int          idle_err = 0;
    bit          mon_en = 1'b0;
    bit          loop_en = 1'b0;
    logic [10:0] bc;
    logic [15:0] cod_l = 16'h0000, cod_r = 16'h0000;
    logic [15:0] acc = 16'h0000, aout_l = 16'h0000, aout_r = 16'h0000;
    logic        model_bit = 1'b0;

    assign SDout = loop_en ? SDin : model_bit;

    // Reference frame counter: restarts at 0 with reset, advances once per clk.
    always @(posedge clk) begin
        if (rst) bc <= 11'd0;
        else     bc <= bc + 11'd1;
    end

    // Codec model: drive ADC bits, decode DAC bits mid-slot, watch the clocks.
    always @(negedge clk) begin
        logic [4:0]  k;
        logic [15:0] w;
        k = bc[9:5];
        w = bc[10] ? cod_r : cod_l;
        model_bit = (k >= 5'd1 && k <= 5'd16) ? w[5'd16 - k] : 1'b0;
        if (mon_en && !rst) begin
            if (MCLK !== bc[1] || SCLK !== bc[4] || LRCLK !== bc[10]) clk_err++;
            if (bc[4:0] == 5'd16) begin
                if (k >= 5'd1 && k <= 5'd16) acc = {acc[14:0], SDin};
                else if (SDin !== 1'b0)      idle_err++;
            end
            if (bc == 11'd1023) aout_l = acc;
            if (bc == 11'd2047) aout_r = acc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        @(posedge clk);
        for (int n = 0; n < 2200; n++) begin
            @(negedge clk);
            if (valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bc(input logic [10:0] target, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2200; n++) begin
            @(negedge clk);
            if (bc == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int cycles;
        int vseen;

        vecs[0] = '{16'h1234, 16'hABCD, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE, 16'h0000, 16'h0000};
        vecs[1] = '{16'hFFFF, 16'h0000, 16'h0F0F, 16'hF0F0, 16'h0F0F, 16'hF0F0, 16'h1234, 16'hABCD};
        vecs[2] = '{16'h8000, 16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[3] = '{16'h5A5A, 16'hA5A5, 16'h0001, 16'h8000, 16'h0001, 16'h8000, 16'h8000, 16'h0001};

        rst = 1'b1;
        lft_out = 16'h0000;
        rht_out = 16'h0000;
        repeat (4) @(negedge clk);
        chk("rst_clocks", {MCLK, SCLK, LRCLK}, 32'd0);
        chk("rst_sdin_valid", {SDin, valid}, 32'd0);
        chk("rst_rstn", RSTn, 32'd0);
        chk("rst_lft_in", lft_in, 32'd0);
        chk("rst_rht_in", rht_in, 32'd0);

        mon_en = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstn_release", RSTn, 32'd1);

        for (int i = 0; i < 4; i++) begin
            lft_out = vecs[i].tx_l;
            rht_out = vecs[i].tx_r;
            cod_l   = vecs[i].cod_l;
            cod_r   = vecs[i].cod_r;
            wait_valid(ok);
            chk("vec_valid_seen", ok, 32'd1);
            if (i == 0) chk("lrclk_low_at_wrap", LRCLK, 32'd0);
            chk("vec_lft_in", lft_in, vecs[i].exp_l);
            chk("vec_rht_in", rht_in, vecs[i].exp_r);
            chk("vec_aout_lft", aout_l, vecs[i].exp_al);
            chk("vec_aout_rht", aout_r, vecs[i].exp_ar);
            @(posedge clk); #1;
            chk("valid_one_clk", valid, 32'd0);
        end

        // Input isolation: lft_out changes mid-frame after capture.
        lft_out = 16'h1234;
        rht_out = 16'hABCD;
        wait_valid(ok);
        @(posedge clk); #1;
        wait_bc(11'd500, ok);
        chk("iso_reach_500", ok, 32'd1);
        lft_out = 16'h5555;
        wait_valid(ok);
        chk("iso_aout_lft", aout_l, 32'h1234);
        chk("iso_aout_rht", aout_r, 32'hABCD);
        wait_valid(ok);
        chk("iso_next_lft", aout_l, 32'h5555);

        // Reset in the middle of the right half-frame.
        cod_l = 16'h1111;
        cod_r = 16'h2222;
        wait_bc(11'd1500, ok);
        chk("rst_reach_1500", ok, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_outputs", {MCLK, SCLK, LRCLK, SDin, valid, RSTn}, 32'd0);
        chk("mid_rst_lft_in", lft_in, 32'd0);
        chk("mid_rst_rht_in", rht_in, 32'd0);
        vseen = 0;
        repeat (3) begin
            @(negedge clk);
            if (valid) vseen++;
        end
        chk("mid_rst_no_valid", vseen, 32'd0);
        cod_l = 16'h3333;
        cod_r = 16'h4444;
        rst = 1'b0;
        cycles = 0;
        ok = 1'b0;
        for (int n = 0; n < 2200; n++) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("post_rst_valid_seen", ok, 32'd1);
        chk("post_rst_latency", cycles, 32'd2048);
        chk("post_rst_lft_in", lft_in, 32'h3333);
        chk("post_rst_rht_in", rht_in, 32'h4444);
        chk("post_rst_aout_lft", aout_l, 32'h0000);
        chk("post_rst_aout_rht", aout_r, 32'h0000);

        // Loopback: SDin returns on SDout, one frame of latency.
        lft_out = 16'hFFFF;
        rht_out = 16'h0000;
        loop_en = 1'b1;
        wait_valid(ok);
        wait_valid(ok);
        chk("loop_valid_seen", ok, 32'd1);
        chk("loop_lft_in", lft_in, 32'hFFFF);
        chk("loop_rht_in", rht_in, 32'h0000);

        chk("clock_monitor", clk_err, 32'd0);
        chk("sdin_idle_slots", idle_err, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/codec_intf.md
CODEC_INTF -- requirements
Module: codec_intf

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width delivered to and accepted from the equalizer datapath.
REQ-002 SHALL have port clk  input  1  system clock; sole clock, all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port MCLK  output  1  codec master clock, clk/4.
REQ-005 SHALL have port SCLK  output  1  codec serial bit clock, clk/32.
REQ-006 SHALL have port LRCLK  output  1  frame clock, clk/2048; low = left channel, high = right channel.
REQ-007 SHALL have port RSTn  output  1  codec reset, active-low.
REQ-008 SHALL have port SDout  input  1  serial ADC data from codec, I2S format.
REQ-009 SHALL have port SDin  output  1  serial DAC data to codec, I2S format.
REQ-010 SHALL have port lft_in  output  DATA_W  last complete left sample received, signed.
REQ-011 SHALL have port rht_in  output  DATA_W  last complete right sample received, signed.
REQ-012 SHALL have port valid  output  1  one-clk pulse: lft_in/rht_in updated, lft_out/rht_out captured.
REQ-013 SHALL have port lft_out  input  DATA_W  left sample to transmit, signed.
REQ-014 SHALL have port rht_out  input  DATA_W  right sample to transmit, signed.

Function
REQ-015 SHALL derive all codec clocks from one 11-bit free-running counter cnt: MCLK=cnt[1], SCLK=cnt[4], LRCLK=cnt[10]; cnt wraps 2047->0.
REQ-016 SHALL define an SCLK rise as cnt[4:0] transitioning 01111->10000 and an SCLK fall as 11111->00000.
REQ-017 SHALL define the bit slot within a channel half as k=cnt[9:5], range 0..31.
REQ-018 SHALL sample SDout on the SCLK rise of slots k=1..16, MSB first; slot 0 is the I2S one-bit delay; slots 17..31 are ignored.
REQ-019 SHALL latch the 16 received left bits into lft_in when cnt transitions 1023->1024.
REQ-020 SHALL latch the 16 received right bits into rht_in when cnt transitions 2047->0, and assert valid for exactly that one clk (cnt==0).
REQ-021 SHALL capture lft_out and rht_out into internal transmit holding registers in the same clk as valid; changes to lft_out/rht_out at any other time SHALL NOT affect the frame in flight.
REQ-022 SHALL drive SDin on SCLK falls: slot k=1..16 carries bit (16-k) of the held word, MSB first; SDin=0 during slot 0 and slots 17..31.
REQ-023 SHALL transmit the held left word while LRCLK is low and the held right word while LRCLK is high.
REQ-024 SHALL give a round-trip latency of exactly one frame: a word captured at valid appears on SDin during the next frame.
REQ-025 SHALL treat all sample data as opaque two's-complement; no rounding, saturation or sign manipulation.

Reset
REQ-026 SHALL, while rst=1, force cnt=0, MCLK=SCLK=LRCLK=0, SDin=0, valid=0, lft_in=rht_in=0, transmit holding registers=0, receive shifter=0.
REQ-027 SHALL hold RSTn=0 while rst=1 and drive RSTn=1 starting one clk after rst deasserts.
REQ-028 SHALL, on rst asserted mid-frame, abort the frame; partially shifted bits SHALL NOT be latched, and valid SHALL NOT pulse.
REQ-029 SHALL produce the first valid pulse 2048 clks after rst deasserts.

Structure
REQ-030 SHALL place CNT_W=11, DATA_W default, the MCLK/SCLK/LRCLK counter bit indices, and the first/last data slot numbers (1, 16) in shared package codec_pkg.
REQ-031 SHALL implement the counter and clock decode in one sub-module, codec_clk_gen, which exports cnt, sclk_rise, sclk_fall, lr_rise and frame_wrap strobes; codec_intf instantiates it once.

Verification
REQ-032 SHALL verify clocks: after reset release, MCLK period=4 clk, SCLK period=32 clk, LRCLK period=2048 clk, all 50% duty, LRCLK=0 at first cnt=0.
REQ-033 SHALL verify receive: codec model sends left 16'h8001, right 16'h7FFE -> valid pulses at frame end with lft_in=16'h8001, rht_in=16'h7FFE.
REQ-034 SHALL verify transmit: lft_out=16'h1234, rht_out=16'hABCD at valid -> SDin serializes 0x1234 in left slots 1..16 and 0xABCD in right slots 1..16 of the next frame; model aout_lft=0x1234, aout_rht=0xABCD.
REQ-035 SHALL verify input isolation: change lft_out 0x1234->0x5555 at cnt=500 -> the frame in flight still transmits 0x1234.
REQ-036 SHALL verify reset mid-frame: assert rst at cnt=1500 with a right word half-received -> next clk all outputs at reset values, RSTn=0; no valid until 2048 clks after release; the next valid carries only freshly received data.
REQ-037 SHALL verify loopback: SDin tied to SDout, lft_out=16'hFFFF, rht_out=16'h0000 -> one frame later lft_in=16'hFFFF, rht_in=16'h0000.
